game_move_committer: RTL and testbench

//  Initiator and writer on the far side of game_judger's en/done interface. Accepts a move

---
 rtl/game_move_committer.sv | 174 +++++++++++++++++
 tb/tb_game_move_committer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_move_committer.sv
// Move committer for the 8x8 board: sweeps the board RAM clear, hands each move
// request to game_judger over en/done, and writes accepted stones back into the RAM.
`ifndef SIDE_RED
`define SIDE_RED 1'b0
`endif
`ifndef SIDE_GREEN
`define SIDE_GREEN 1'b1
`endif
`ifndef JUDGER_INVALID
`define JUDGER_INVALID 2'd0
`endif
`ifndef JUDGER_VALID
`define JUDGER_VALID 2'd1
`endif
`ifndef JUDGER_WIN
`define JUDGER_WIN 2'd2
`endif

module game_move_committer #(
    parameter logic FIRST_SIDE  = `SIDE_RED,
    parameter int   BOARD_CELLS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [5:0] move_pos,
    output logic       move_ready,
    output logic       judger_en,
    output logic       judger_color,
    output logic [5:0] judger_pos,
    input  logic [1:0] judger_result,
    input  logic       judger_done,
    output logic       ram_wr_en,
    output logic [5:0] ram_wr_addr,
    output logic [1:0] ram_wr_data,
    output logic       resp_valid,
    output logic [1:0] resp_result,
    output logic       side,
    output logic [6:0] move_count,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_JUDGE   = 3'd2,
        S_COMMIT  = 3'd3,
        S_RELEASE = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam logic [6:0] FULL_COUNT = 7'(BOARD_CELLS);

    state_t     state_r;
    logic [6:0] sweep_r;
    logic [1:0] result_r;

    function automatic logic [1:0] stone_code(input logic color);
        return (color == `SIDE_RED) ? 2'b10 : 2'b01;
    endfunction

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state_r      <= S_CLEAR;
            sweep_r      <= 7'd0;
            result_r     <= `JUDGER_INVALID;
            move_ready   <= 1'b0;
            judger_en    <= 1'b0;
            judger_color <= 1'b0;
            judger_pos   <= 6'd0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= 6'd0;
            ram_wr_data  <= 2'b00;
            resp_valid   <= 1'b0;
            resp_result  <= `JUDGER_INVALID;
            side         <= FIRST_SIDE;
            move_count   <= 7'd0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            draw         <= 1'b0;
        end else begin
            ram_wr_en  <= 1'b0;
            resp_valid <= 1'b0;
            move_ready <= 1'b0;
            case (state_r)
                S_CLEAR: begin
                    // The last sweep write is visible in the final S_CLEAR cycle.
                    if (sweep_r < FULL_COUNT) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= sweep_r[5:0];
                        ram_wr_data <= 2'b00;
                        sweep_r     <= sweep_r + 7'd1;
                    end else begin
                        state_r    <= S_IDLE;
                        move_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (move_valid && move_ready) begin
                        judger_pos   <= move_pos;
                        judger_color <= side;
                        judger_en    <= 1'b1;
                        state_r      <= S_JUDGE;
                    end else begin
                        move_ready <= 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (judger_done) begin
                        result_r <= judger_result;
                        if (judger_result == `JUDGER_INVALID) begin
                            judger_en   <= 1'b0;
                            resp_valid  <= 1'b1;
                            resp_result <= judger_result;
                            state_r     <= S_RELEASE;
                        end else begin
                            ram_wr_en   <= 1'b1;
                            ram_wr_addr <= judger_pos;
                            ram_wr_data <= stone_code(judger_color);
                            state_r     <= S_COMMIT;
                        end
                    end else begin
                        state_r <= S_JUDGE;
                    end
                end
                S_COMMIT: begin
                    if (move_count != FULL_COUNT) begin
                        move_count <= move_count + 7'd1;
                    end else begin
                        move_count <= move_count;
                    end
                    if (result_r == `JUDGER_WIN) begin
                        game_over <= 1'b1;
                        winner    <= judger_color;
                    end else if ((move_count + 7'd1) == FULL_COUNT) begin
                        game_over <= 1'b1;
                        draw      <= 1'b1;
                    end else begin
                        side <= ~side;
                    end
                    judger_en   <= 1'b0;
                    resp_valid  <= 1'b1;
                    resp_result <= result_r;
                    state_r     <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Holding here until done falls keeps en low between requests.
                    if (!judger_done) begin
                        if (game_over) begin
                            state_r <= S_OVER;
                        end else begin
                            state_r    <= S_IDLE;
                            move_ready <= 1'b1;
                        end
                    end else begin
                        state_r <= S_RELEASE;
                    end
                end
                S_OVER: begin
                    state_r <= S_OVER;
                end
                default: begin
                    state_r <= S_CLEAR;
                    sweep_r <= 7'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_move_committer.sv
// Randomized bench for game_move_committer: a judger stand-in drives done/result and
// a board-level model predicts writes, verdicts and game statistics.
`ifndef SIDE_RED
`define SIDE_RED 1'b0
`endif
`ifndef JUDGER_INVALID
`define JUDGER_INVALID 2'd0
`endif
`ifndef JUDGER_VALID
`define JUDGER_VALID 2'd1
`endif
`ifndef JUDGER_WIN
`define JUDGER_WIN 2'd2
`endif

module tb_game_move_committer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [5:0] move_pos = 6'd0;
    logic       move_ready;
    logic       judger_en;
    logic       judger_color;
    logic [5:0] judger_pos;
    logic [1:0] judger_result = 2'd0;
    logic       judger_done = 1'b0;
    logic       ram_wr_en;
    logic [5:0] ram_wr_addr;
    logic [1:0] ram_wr_data;
    logic       resp_valid;
    logic [1:0] resp_result;
    logic       side;
    logic [6:0] move_count;
    logic       game_over;
    logic       winner;
    logic       draw;

    game_move_committer dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
        .judger_en(judger_en), .judger_color(judger_color), .judger_pos(judger_pos),
        .judger_result(judger_result), .judger_done(judger_done),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .side(side), .move_count(move_count), .game_over(game_over),
        .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];

    // Reference model: plain board occupancy and game statistics.
    int   board[64];
    logic m_side;
    int   m_count;
    logic m_over;
    logic m_winner;
    logic m_draw;

    always @(negedge clk) begin
        cyc++;
        if (ram_wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(ram_wr_addr));
            wr_data_q.push_back(int'(ram_wr_data));
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) board[i] = 0;
        m_side   = `SIDE_RED;
        m_count  = 0;
        m_over   = 1'b0;
        m_winner = 1'b0;
        m_draw   = 1'b0;
    endtask

    function automatic logic [1:0] code_of(input logic s);
        return (s == `SIDE_RED) ? 2'b10 : 2'b01;
    endfunction

    task automatic check_stats(input string tag);
        chk({tag, "_side"},   side, m_side);
        chk({tag, "_count"},  move_count, m_count);
        chk({tag, "_over"},   game_over, m_over);
        chk({tag, "_draw"},   draw, m_draw);
        chk({tag, "_winner"}, winner, m_winner);
    endtask

    task automatic wait_clear();
        int n = 0;
        int bad = 0;
        while (move_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("clear_ready", move_ready, 1);
        chk("clear_nwr", wr_addr_q.size(), 64);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != i || wr_data_q[i] != 0) bad++;
        end
        chk("clear_seq", bad, 0);
        if (wr_cyc_q.size() == 64) chk("clear_consec", wr_cyc_q[63] - wr_cyc_q[0], 63);
        check_stats("clear");
        clear_writes();
    endtask

    task automatic restart();
        clear_writes();
        new_game = 1'b1;
        step();
        new_game    = 1'b0;
        judger_done = 1'b0;
        chk("ng_en_low", judger_en, 0);
        chk("ng_no_resp", resp_valid, 0);
        chk("ng_no_wr", ram_wr_en, 0);
        model_clear();
        wait_clear();
    endtask

    task automatic do_move(input logic [5:0] pos, input logic [1:0] res, input int dly);
        int n = 0;
        while (move_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_before_move", move_ready, 1);
        clear_writes();
        move_valid = 1'b1;
        move_pos   = pos;
        step();
        move_valid = 1'b0;
        chk("en_after_accept", judger_en, 1);
        chk("judger_pos", judger_pos, pos);
        chk("judger_color", judger_color, m_side);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("en_hold", judger_en, 1);
        end
        judger_result = res;
        judger_done   = 1'b1;
        step();
        if (res != `JUDGER_INVALID) begin
            chk("commit_wr_en", ram_wr_en, 1);
            chk("commit_addr", ram_wr_addr, pos);
            chk("commit_data", ram_wr_data, code_of(m_side));
            chk("commit_no_resp", resp_valid, 0);
            step();
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_result", resp_result, res);
        chk("en_released", judger_en, 0);
        step();
        chk("resp_pulse", resp_valid, 0);
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        judger_done = 1'b0;
        if (res != `JUDGER_INVALID) begin
            board[pos] = 1;
            m_count++;
            if (res == `JUDGER_WIN) begin
                m_over   = 1'b1;
                m_winner = m_side;
            end else if (m_count == 64) begin
                m_over = 1'b1;
                m_draw = 1'b1;
            end else begin
                m_side = ~m_side;
            end
        end
        n = 0;
        while (move_ready !== 1'b1 && n < 10 && !m_over) begin
            step();
            n++;
        end
        step();
        chk("ready_after", move_ready, m_over ? 0 : 1);
        chk("nwrites", wr_addr_q.size(), (res != `JUDGER_INVALID) ? 1 : 0);
        check_stats("move");
    endtask

    task automatic random_game(input int win_odds);
        logic [5:0] p;
        logic [1:0] r;
        for (int m = 0; m < 90 && !m_over; m++) begin
            p = 6'($urandom_range(0, 63));
            if (board[p] != 0) r = `JUDGER_INVALID;
            else if ($urandom_range(0, win_odds) == 0) r = `JUDGER_WIN;
            else r = `JUDGER_VALID;
            do_move(p, r, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int perm[64];
        int j;
        int t;
        logic [5:0] p;
        model_clear();
        step();
        step();
        chk("rst_side", side, `SIDE_RED);
        chk("rst_ready", move_ready, 0);
        chk("rst_en", judger_en, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_count", move_count, 0);
        chk("rst_over", game_over, 0);
        clear_writes();
        rst_n = 1'b1;
        wait_clear();

        do_move(6'o33, `JUDGER_VALID, 1);
        do_move(6'o33, `JUDGER_INVALID, 2);
        p = 6'o12;
        do_move(p, `JUDGER_WIN, 0);
        chk("win_green", winner, 1);
        move_valid = 1'b1;
        move_pos   = 6'o45;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("over_ready", move_ready, 0);
            chk("over_en", judger_en, 0);
        end
        move_valid = 1'b0;
        restart();

        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 64; i++) do_move(6'(perm[i]), `JUDGER_VALID, int'($urandom_range(0, 2)));
        chk("draw_flag", draw, 1);
        chk("draw_over", game_over, 1);
        restart();

        while (move_ready !== 1'b1) step();
        move_valid = 1'b1;
        move_pos   = 6'd9;
        step();
        move_valid = 1'b0;
        chk("ng_judge_en", judger_en, 1);
        step();
        restart();
        for (int i = 0; i < 10; i++) step();
        restart();

        for (int g = 0; g < 3; g++) begin
            random_game(12);
            restart();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
